// File: rtl/cplx_delay_line.sv
// cplx_delay_line: variable-depth delay line for complex samples.
//
// A chain of MAX_DEPTH stages shifts {re, img, vld} on every enabled edge.
// The output is a combinational tap of stage d-1, where d is the requested
// depth clamped to 1..MAX_DEPTH, giving a latency of d enabled edges.
// A fill counter tracks how many enabled edges have passed since the last
// reset, flush or depth change. 'primed' reports that count has reached d.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   en                 shift enable (all state holds when low)
//   flush              clears every valid bit, the fill counter and primed
//   depth[SW]          requested delay in enabled cycles
//   a_re/a_img/a_vld   input sample
//   a1_re/a1_img/a1_vld delayed sample (tap of stage d-1)
//   primed             fill counter has reached d
//   depth_err          sticky: depth=0 or depth>MAX_DEPTH was seen

// One delay stage. The vector is {re, img, vld}, with vld in bit 0.
module cplx_delay_stage #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            // Data shifts whenever enabled. The valid bit is cleared by
            // flush, which also kills the sample captured on that edge.
            if (en) q[W-1:1] <= d[W-1:1];
            if (flush)   q[0] <= 1'b0;
            else if (en) q[0] <= d[0];
        end
    end
endmodule

module cplx_delay_line #(
    parameter int DW        = 32,
    parameter int MAX_DEPTH = 16,
    parameter int SW        = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          flush,
    input  logic [SW-1:0] depth,
    input  logic [DW-1:0] a_re,
    input  logic [DW-1:0] a_img,
    input  logic          a_vld,
    output logic [DW-1:0] a1_re,
    output logic [DW-1:0] a1_img,
    output logic          a1_vld,
    output logic          primed,
    output logic          depth_err
);
    localparam int            SMP_W = 2 * DW + 1;
    localparam logic [SW-1:0] MAXD  = SW'(MAX_DEPTH);

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] img;
        logic          vld;
    } smp_t;

    // chain[0] is the input; chain[k+1] is the output of stage k.
    smp_t [MAX_DEPTH:0] chain;
    smp_t               tap;

    logic [SW-1:0] d, d_q, fc, fc_nxt;
    logic          depth_bad, d_chg;

    assign chain[0] = {a_re, a_img, a_vld};

    for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_stg
        cplx_delay_stage #(.W(SMP_W)) u_stg (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .flush (flush),
            .d     (chain[k]),
            .q     (chain[k+1])
        );
    end

    // Clamp the requested depth into 1..MAX_DEPTH.
    always_comb begin
        depth_bad = (depth == '0) || (depth > MAXD);
        if (depth == '0)       d = SW'(1);
        else if (depth > MAXD) d = MAXD;
        else                   d = depth;
    end

    // Output tap: stage d-1, i.e. chain[d].
    always_comb begin
        tap = chain[1];
        for (int k = 1; k < MAX_DEPTH; k++)
            if (d == SW'(k + 1)) tap = chain[k+1];
    end

    assign a1_re  = tap.re;
    assign a1_img = tap.img;
    assign a1_vld = tap.vld;

    // d_q == 0 only straight after reset, so the first edge after release
    // counts as a fill step rather than a depth change.
    assign d_chg  = (d_q != '0) && (d != d_q);
    assign fc_nxt = (fc < d) ? fc + SW'(1) : d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fc        <= '0;
            d_q       <= '0;
            primed    <= 1'b0;
            depth_err <= 1'b0;
        end else begin
            if (depth_bad) depth_err <= 1'b1;
            d_q <= d;
            if (flush || d_chg) begin
                fc     <= '0;
                primed <= 1'b0;
            end else if (en) begin
                fc     <= fc_nxt;
                primed <= (fc_nxt >= d);
            end
        end
    end
endmodule
